// File: rtl/finv_sched_pkg.sv
// Shared constants and types for the finv request scheduler.
package finv_sched_pkg;

    // Pipeline depth of the finv datapath; single source for the LATENCY default.
    localparam int unsigned FinvLatency  = 4;
    localparam int unsigned NreqDefault  = 2;
    localparam int unsigned IdWDefault   = 1;
    localparam int unsigned DepthDefault = 8;

    // Widest requester ID the response entry can carry.
    localparam int unsigned IdWMax = 8;

    typedef struct packed {
        logic [31:0]       data;
        logic [IdWMax-1:0] id;
    } rsp_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with registered head (no write-to-read bypass).
// Depth need not be a power of two; pointers wrap explicitly.
module sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, wr_d;
    logic [PtrW-1:0]  rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign push_en = push_i & (~full_o | pop_i);
    assign pop_en  = pop_i & ~empty_o;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_en) begin
            wr_d = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
        end
        if (pop_en) begin
            rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
        end
        unique case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/finv_sched.sv
// Round-robin scheduler sharing one fixed-latency reciprocal pipeline between
// NREQ requesters. Issue is credit-limited so the non-stallable pipeline can
// always land its results in the response FIFO.
module finv_sched
    import finv_sched_pkg::*;
#(
    parameter int unsigned NREQ    = NreqDefault,
    parameter int unsigned ID_W    = IdWDefault,
    parameter int unsigned LATENCY = FinvLatency,
    parameter int unsigned DEPTH   = DepthDefault
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [32*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [31:0]        fu_s,
    input  logic [31:0]        fu_d,
    output logic               rsp_valid,
    output logic [31:0]        rsp_data,
    output logic [ID_W-1:0]    rsp_id,
    input  logic               rsp_ready,
    output logic               idle
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [ID_W-1:0]    rr_q, rr_d;
    logic [LATENCY-1:0] vld_q;
    logic [ID_W-1:0]    tag_q [LATENCY];
    logic [CntW-1:0]    inflight_q, inflight_d;
    logic [CntW-1:0]    fifo_cnt;
    logic [CntW:0]      occ;
    logic               issue_ok;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;
    logic               issue;
    logic               retire;
    logic               fifo_full;
    logic               fifo_empty;
    rsp_entry_t         push_entry;
    rsp_entry_t         head;
    logic               unused_bits;

    // Credits count both in-flight operands and buffered results; a pop in
    // this cycle is deliberately not credited, keeping rsp_ready off req_ready.
    assign occ      = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign issue_ok = (occ < (CntW + 1)'(DEPTH));

    // Round-robin pick: lowest valid index at or above the pointer, else wrap.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req_valid[i] && (ID_W'(i) >= rr_q)) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end

    // Reset gates the grant so nothing handshakes while rstn is low.
    assign issue = gnt_any & issue_ok & rstn;

    // One-hot ready and operand mux for the granted requester.
    always_comb begin
        req_ready = '0;
        fu_s      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue && (gnt_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                fu_s         = req_data[32*i +: 32];
            end
        end
    end

    // Next pointer and in-flight count.
    always_comb begin
        rr_d = rr_q;
        if (issue) begin
            rr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
        unique case ({issue, retire})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Arbiter pointer and in-flight counter state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q       <= '0;
            inflight_q <= '0;
        end else begin
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
        end
    end

    // Tag pipeline mirrors the finv datapath: a bubble enters when nothing issues.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= issue;
            tag_q[0] <= issue ? gnt_idx : '0;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // The final stage lines up with fu_d for that operand.
    assign retire          = vld_q[LATENCY-1];
    assign push_entry.data = fu_d;
    assign push_entry.id   = IdWMax'(tag_q[LATENCY-1]);

    sync_fifo #(
        .Width ($bits(rsp_entry_t)),
        .Depth (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .push_i  (retire),
        .wdata_i (push_entry),
        .pop_i   (rsp_valid & rsp_ready),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Head fields read as zero while empty so reset outputs are defined.
    assign rsp_valid = ~fifo_empty;
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign rsp_id    = rsp_valid ? head.id[ID_W-1:0] : '0;
    assign idle      = (inflight_q == '0) & (fifo_cnt == '0);

    // Credit logic makes full-with-push impossible; full is kept for observability.
    assign unused_bits = ^{head.id, fifo_full};

endmodule

// File: tb/tb_finv_sched.sv
// Directed bench for finv_sched: two instances (2 requesters / depth 8 and
// 3 requesters / depth 6), each fed by a behavioural stand-in finv pipeline.
module tb_finv_sched;

    localparam int unsigned L = 4;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // Instance A: NREQ=2, DEPTH=8
    logic [1:0]  rv2;
    logic [63:0] rd2;
    logic [1:0]  rr2;
    logic [31:0] fs2, fd2, d2;
    logic        v2, ready2, idle2;
    logic [0:0]  id2;

    // Instance B: NREQ=3, ID_W=2, DEPTH=6
    logic [2:0]  rv3;
    logic [95:0] rd3;
    logic [2:0]  rr3;
    logic [31:0] fs3, fd3, d3;
    logic        v3, ready3, idle3;
    logic [1:0]  id3;

    finv_sched #(.NREQ(2), .ID_W(1), .LATENCY(L), .DEPTH(8)) dut2 (
        .clk(clk), .rstn(rstn), .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
        .fu_s(fs2), .fu_d(fd2), .rsp_valid(v2), .rsp_data(d2), .rsp_id(id2),
        .rsp_ready(ready2), .idle(idle2)
    );

    finv_sched #(.NREQ(3), .ID_W(2), .LATENCY(L), .DEPTH(6)) dut3 (
        .clk(clk), .rstn(rstn), .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
        .fu_s(fs3), .fu_d(fd3), .rsp_valid(v3), .rsp_data(d3), .rsp_id(id3),
        .rsp_ready(ready3), .idle(idle3)
    );

    // Exact reciprocal for powers of two; any other operand gets a fixed
    // reversible scramble so data integrity is still visible.
    function automatic logic [31:0] finv_model(input logic [31:0] x);
        if (x[22:0] == 23'd0 && x[30:23] != 8'd0 && x[30:23] < 8'd254)
            return {x[31], 8'(9'd254 - {1'b0, x[30:23]}), 23'd0};
        return x ^ 32'hA5A5_5A5A;
    endfunction

    logic [31:0] p2 [L];
    logic [31:0] p3 [L];
    always @(posedge clk) begin
        p2[0] <= finv_model(fs2);
        p3[0] <= finv_model(fs3);
        for (int k = 1; k < L; k++) begin
            p2[k] <= p2[k-1];
            p3[k] <= p3[k-1];
        end
    end
    assign fd2 = p2[L-1];
    assign fd3 = p3[L-1];

    // Port-level monitors: popped responses and outstanding-operand count.
    logic [39:0] log2 [$];
    logic [39:0] log3 [$];
    int out2 = 0, max_out2 = 0;
    always @(posedge clk) begin
        if (!rstn) begin
            out2 <= 0;
        end else begin
            out2 <= out2 + ((|(rv2 & rr2)) ? 1 : 0) - ((v2 && ready2) ? 1 : 0);
            if (v2 && ready2) log2.push_back({8'(id2), d2});
            if (v3 && ready3) log3.push_back({8'(id3), d3});
        end
        if (out2 > max_out2) max_out2 <= out2;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
    endtask

    task automatic wait_idle(input int which, input int budget);
        int n = 0;
        while (((which == 2) ? !idle2 : !idle3) && n < budget) begin
            cyc();
            n++;
        end
        chk("idle_wait", (which == 2) ? idle2 : idle3, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int hs;
        int rvcnt;
        int ep;
        logic [31:0] ld [3];
        logic [39:0] exp3 [$];

        // Reset values, with requests pending to show ready is held off.
        rstn = 1'b0; rv2 = 2'b11; rd2 = {32'h4080_0000, 32'h4000_0000}; ready2 = 1'b0;
        rv3 = '0; rd3 = '0; ready3 = 1'b0;
        #2;
        chk("rst_ready", rr2, 0);
        chk("rst_rsp_valid", v2, 0);
        chk("rst_rsp_id", id2, 0);
        chk("rst_rsp_data", d2, 0);
        chk("rst_fu_s", fs2, 0);
        chk("rst_idle", idle2, 1);
        rv2 = '0;
        cyc(); cyc();
        rstn = 1'b1;
        cyc();

        // Single op: response LATENCY+1 cycles after the handshake.
        rv2 = 2'b01; rd2[31:0] = 32'h3F80_0000; ready2 = 1'b1;
        #1;
        chk("t1_gnt", rr2, 2'b01);
        chk("t1_fu_s", fs2, 32'h3F80_0000);
        cyc();
        rv2 = '0;
        for (int i = 1; i <= L; i++) begin
            #1 chk("t1_early", v2, 0);
            cyc();
        end
        #1;
        chk("t1_valid", v2, 1);
        chk("t1_data", d2, 32'h3F80_0000);
        chk("t1_id", id2, 0);
        chk("t1_busy", idle2, 0);
        cyc();
        chk("t1_idle", idle2, 1);
        chk("t1_empty", v2, 0);

        // Fairness: grants alternate from pointer 0.
        do_reset();
        log2.delete();
        rv2 = 2'b11; rd2 = {32'h4080_0000, 32'h4000_0000};
        for (int i = 0; i < 6; i++) begin
            #1 chk("t2_gnt", rr2, (i % 2 == 0) ? 2'b01 : 2'b10);
            cyc();
        end
        rv2 = '0;
        wait_idle(2, 50);
        chk("t2_count", log2.size(), 6);
        for (int i = 0; i < 6 && i < log2.size(); i++)
            chk("t2_rsp", log2[i], {8'(i % 2), (i % 2 == 1) ? 32'h3E80_0000 : 32'h3F00_0000});

        // Backpressure: exactly DEPTH credits, resume one cycle after first pop.
        log2.delete();
        ready2 = 1'b0; rv2 = 2'b01; hs = 0;
        for (int c = 0; c < 16; c++) begin
            rd2[31:0] = 32'hC0DE_0000 + 32'(hs);
            #1;
            if (rr2[0]) hs++;
            cyc();
        end
        chk("t3_handshakes", hs, 8);
        #1;
        chk("t3_blocked", rr2, 0);
        chk("t3_head_valid", v2, 1);
        chk("t3_head_data", d2, finv_model(32'hC0DE_0000));
        ready2 = 1'b1;
        #1 chk("t3_no_same_cycle", rr2, 0);
        cyc();
        #1 chk("t3_resume", rr2, 2'b01);
        cyc();
        rv2 = '0;
        wait_idle(2, 60);
        chk("t3_count", log2.size(), 9);
        for (int i = 0; i < 9 && i < log2.size(); i++)
            chk("t3_rsp", log2[i], {8'd0, finv_model(32'hC0DE_0000 + 32'(i))});

        // Full throughput: one issue and one response per cycle.
        log2.delete();
        rv2 = 2'b01; hs = 0; rvcnt = 0;
        for (int c = 0; c < 30; c++) begin
            rd2[31:0] = 32'h4455_0000 + 32'(c);
            #1;
            if (rr2[0]) hs++;
            if (c >= 10 && v2) rvcnt++;
            cyc();
        end
        chk("t4_issues", hs, 30);
        chk("t4_rsp_cycles", rvcnt, 20);
        rv2 = '0;
        wait_idle(2, 60);
        chk("t4_count", log2.size(), 30);
        for (int i = 0; i < 30 && i < log2.size(); i++)
            chk("t4_rsp", log2[i], {8'd0, finv_model(32'h4455_0000 + 32'(i))});
        chk("t4_occ_bound", (max_out2 <= 8) ? 1 : 0, 1);

        // Reset one cycle before the first retire drops everything.
        log2.delete();
        rv2 = 2'b01; rd2[31:0] = 32'h3F80_0000;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_gnt", rr2, 2'b01);
            cyc();
        end
        rv2 = '0;
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t5_no_rsp", v2, 0);
            chk("t5_idle", idle2, 1);
            cyc();
        end
        chk("t5_no_pops", log2.size(), 0);
        rv2 = 2'b11;
        #1 chk("t5_ptr_cleared", rr2, 2'b01);
        cyc();
        rv2 = '0;
        wait_idle(2, 30);

        // NREQ=3: pointer moved to 2 by a req1 op, then req2/req0 alternate.
        log3.delete();
        exp3.delete();
        ready3 = 1'b1;
        rv3 = 3'b010; rd3[63:32] = 32'h3F80_0000;
        #1 chk("t6_pre", rr3, 3'b010);
        exp3.push_back({8'd1, finv_model(32'h3F80_0000)});
        cyc();
        rv3 = 3'b101; rd3[31:0] = 32'h4000_0000; rd3[95:64] = 32'h4080_0000;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t6_gnt", rr3, (i % 2 == 0) ? 3'b100 : 3'b001);
            exp3.push_back((i % 2 == 0) ? {8'd2, 32'h3E80_0000} : {8'd0, 32'h3F00_0000});
            cyc();
        end

        // Stream all three under intermittent backpressure; depth 6 wraps repeatedly.
        rv3 = 3'b111; ep = 1; hs = 0;
        for (int c = 0; c < 200 && hs < 24; c++) begin
            for (int i = 0; i < 3; i++) begin
                ld[i] = 32'h1000_0000 * 32'(i + 1) + 32'(c);
                rd3[32*i +: 32] = ld[i];
            end
            ready3 = (c % 3 != 0);
            #1;
            if (rr3 != 3'b000) begin
                chk("t6_rr", rr3, 3'b001 << ep);
                exp3.push_back({8'(ep), finv_model(ld[ep])});
                ep = (ep + 1) % 3;
                hs++;
            end
            cyc();
        end
        chk("t6_handshakes", hs, 24);
        rv3 = '0; ready3 = 1'b1;
        wait_idle(3, 80);
        chk("t6_count", log3.size(), exp3.size());
        for (int i = 0; i < exp3.size() && i < log3.size(); i++)
            chk("t6_rsp", log3[i], exp3[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
